// File: rtl/regfile_wb_sink_if.sv
// Writeback/decode/debug bundle between the pipeline and the integer register file.
interface regfile_wb_sink_if #(
    parameter int unsigned XLEN = 32
) ();

    logic            REGWRITE_W_i;
    logic [4:0]      RD_W_i;
    logic [XLEN-1:0] RSLT_W_i;
    logic [4:0]      RS1_D_i;
    logic [4:0]      RS2_D_i;
    logic [4:0]      DBG_ADDR_i;
    logic [XLEN-1:0] RD1_D_o;
    logic [XLEN-1:0] RD2_D_o;
    logic [XLEN-1:0] DBG_DATA_o;
    logic [31:0]     WR_CNT_o;

    // Pipeline side: drives writeback and read indices, consumes read data.
    modport master (
        output REGWRITE_W_i, RD_W_i, RSLT_W_i, RS1_D_i, RS2_D_i, DBG_ADDR_i,
        input  RD1_D_o, RD2_D_o, DBG_DATA_o, WR_CNT_o
    );

    // Register file side.
    modport slave (
        input  REGWRITE_W_i, RD_W_i, RSLT_W_i, RS1_D_i, RS2_D_i, DBG_ADDR_i,
        output RD1_D_o, RD2_D_o, DBG_DATA_o, WR_CNT_o
    );

endinterface

// File: rtl/regfile_wb_sink.sv
// RV32I integer register file: one writeback port, two decode read ports with
// same-cycle WB->ID bypass, one unbypassed debug read port and a commit counter.
module regfile_wb_sink #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned NREGS     = 32,
    parameter bit          BYPASS_EN = 1'b1
) (
    input  logic              CLK_i,
    input  logic              RST_N_i,
    regfile_wb_sink_if.slave  wb_if
);

    logic [XLEN-1:0] r_regs [NREGS];
    logic [31:0]     r_wr_cnt;
    logic [31:0]     w_wr_cnt_d;
    logic            w_wr_valid;
    logic [XLEN-1:0] w_rd1;
    logic [XLEN-1:0] w_rd2;
    logic [XLEN-1:0] w_dbg;

    // Committed-state lookup; x0 and out-of-range indices read as zero.
    function automatic logic [XLEN-1:0] lookup(input logic [4:0] idx);
        logic [XLEN-1:0] val;
        val = '0;
        for (int i = 1; i < int'(NREGS); i++) begin
            if (idx == 5'(i)) begin
                val = r_regs[i];
            end
        end
        return val;
    endfunction

    // A write is real only for x1..x(NREGS-1); gating with reset keeps reads at 0 while held.
    always_comb begin
        w_wr_valid = RST_N_i && wb_if.REGWRITE_W_i && (wb_if.RD_W_i != 5'd0) &&
                     (32'(wb_if.RD_W_i) < NREGS);
        w_wr_cnt_d = w_wr_valid ? (r_wr_cnt + 32'd1) : r_wr_cnt;
    end

    // Register array: async clear, single write port, x0 never stored.
    always_ff @(posedge CLK_i or negedge RST_N_i) begin
        if (!RST_N_i) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < int'(NREGS); i++) begin
                if (w_wr_valid && (wb_if.RD_W_i == 5'(i))) begin
                    r_regs[i] <= wb_if.RSLT_W_i;
                end
            end
        end
    end

    // Commit counter, wraps modulo 2^32.
    always_ff @(posedge CLK_i or negedge RST_N_i) begin
        if (!RST_N_i) begin
            r_wr_cnt <= '0;
        end else begin
            r_wr_cnt <= w_wr_cnt_d;
        end
    end

    // Decode reads: forward the in-flight write when it targets the same register.
    always_comb begin
        w_rd1 = '0;
        w_rd2 = '0;
        if (wb_if.RS1_D_i != 5'd0) begin
            if (BYPASS_EN && w_wr_valid && (wb_if.RD_W_i == wb_if.RS1_D_i)) begin
                w_rd1 = wb_if.RSLT_W_i;
            end else begin
                w_rd1 = lookup(wb_if.RS1_D_i);
            end
        end
        if (wb_if.RS2_D_i != 5'd0) begin
            if (BYPASS_EN && w_wr_valid && (wb_if.RD_W_i == wb_if.RS2_D_i)) begin
                w_rd2 = wb_if.RSLT_W_i;
            end else begin
                w_rd2 = lookup(wb_if.RS2_D_i);
            end
        end
    end

    // Debug read shows committed state only.
    always_comb begin
        w_dbg = lookup(wb_if.DBG_ADDR_i);
    end

    assign wb_if.RD1_D_o    = w_rd1;
    assign wb_if.RD2_D_o    = w_rd2;
    assign wb_if.DBG_DATA_o = w_dbg;
    assign wb_if.WR_CNT_o   = r_wr_cnt;

endmodule

// File: tb/tb_regfile_wb_sink.sv
// Directed bench for regfile_wb_sink: table of per-cycle vectors plus reset and
// counter-wrap sequences. A second instance with bypass disabled runs in lockstep.
module tb_regfile_wb_sink;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    regfile_wb_sink_if #(.XLEN(32)) if_b ();
    regfile_wb_sink_if #(.XLEN(32)) if_nb ();

    regfile_wb_sink #(.XLEN(32), .NREGS(32), .BYPASS_EN(1'b1)) dut_b (
        .CLK_i   (clk),
        .RST_N_i (rst_n),
        .wb_if   (if_b.slave)
    );

    regfile_wb_sink #(.XLEN(32), .NREGS(32), .BYPASS_EN(1'b0)) dut_nb (
        .CLK_i   (clk),
        .RST_N_i (rst_n),
        .wb_if   (if_nb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] rslt;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  dbg;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
        logic [31:0] e_dbg;
        logic [31:0] e_cnt;
        logic [31:0] e_nb_rd1;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] rd, input logic [31:0] rslt,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] dbg);
        if_b.REGWRITE_W_i  = we;   if_nb.REGWRITE_W_i = we;
        if_b.RD_W_i        = rd;   if_nb.RD_W_i       = rd;
        if_b.RSLT_W_i      = rslt; if_nb.RSLT_W_i     = rslt;
        if_b.RS1_D_i       = rs1;  if_nb.RS1_D_i      = rs1;
        if_b.RS2_D_i       = rs2;  if_nb.RS2_D_i      = rs2;
        if_b.DBG_ADDR_i    = dbg;  if_nb.DBG_ADDR_i   = dbg;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        //            we  rd     rslt           rs1    rs2    dbg    rd1            rd2            dbg            cnt    nb_rd1
        vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  5'd5,  32'hDEADBEEF, 32'h0,        32'h0,        32'd0, 32'h0};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'd1, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 5'd0,  32'h12345678, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'd1, 32'h0};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'd1, 32'h0};
        vecs[4]  = '{1'b1, 5'd7,  32'h11,       5'd7,  5'd5,  5'd7,  32'h11,       32'hDEADBEEF, 32'h0,        32'd1, 32'h0};
        vecs[5]  = '{1'b1, 5'd7,  32'h22,       5'd7,  5'd7,  5'd7,  32'h22,       32'h22,       32'h11,       32'd2, 32'h11};
        vecs[6]  = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  5'd7,  32'h22,       32'h22,       32'h22,       32'd3, 32'h22};
        vecs[7]  = '{1'b1, 5'd3,  32'h1,        5'd3,  5'd7,  5'd3,  32'h1,        32'h22,       32'h0,        32'd3, 32'h0};
        vecs[8]  = '{1'b1, 5'd3,  32'h2,        5'd3,  5'd3,  5'd3,  32'h2,        32'h2,        32'h1,        32'd4, 32'h1};
        vecs[9]  = '{1'b1, 5'd3,  32'h3,        5'd3,  5'd0,  5'd3,  32'h3,        32'h0,        32'h2,        32'd5, 32'h2};
        vecs[10] = '{1'b0, 5'd3,  32'h99,       5'd3,  5'd31, 5'd3,  32'h3,        32'h0,        32'h3,        32'd6, 32'h3};
        vecs[11] = '{1'b1, 5'd31, 32'hA5A5A5A5, 5'd31, 5'd3,  5'd31, 32'hA5A5A5A5, 32'h3,        32'h0,        32'd6, 32'h0};
        vecs[12] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd5,  5'd31, 32'hA5A5A5A5, 32'hDEADBEEF, 32'hA5A5A5A5, 32'd7, 32'hA5A5A5A5};

        rst_n = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
        repeat (2) @(negedge clk);
        chk("reset_cnt", if_b.WR_CNT_o, 32'd0);
        chk("reset_rd1", if_b.RD1_D_o, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            drive(vecs[i].we, vecs[i].rd, vecs[i].rslt, vecs[i].rs1, vecs[i].rs2, vecs[i].dbg);
            #1;
            chk($sformatf("v%0d_rd1", i), if_b.RD1_D_o, vecs[i].e_rd1);
            chk($sformatf("v%0d_rd2", i), if_b.RD2_D_o, vecs[i].e_rd2);
            chk($sformatf("v%0d_dbg", i), if_b.DBG_DATA_o, vecs[i].e_dbg);
            chk($sformatf("v%0d_cnt", i), if_b.WR_CNT_o, vecs[i].e_cnt);
            chk($sformatf("v%0d_nb_rd1", i), if_nb.RD1_D_o, vecs[i].e_nb_rd1);
        end

        // Mid-run reset with a write pending: the write is lost, everything reads 0.
        @(negedge clk);
        drive(1'b1, 5'd9, 32'h55, 5'd9, 5'd31, 5'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_hold_rd1", if_b.RD1_D_o, 32'd0);
        chk("rst_hold_rd2", if_b.RD2_D_o, 32'd0);
        chk("rst_hold_cnt", if_b.WR_CNT_o, 32'd0);
        @(posedge clk);
        #1;
        for (int r = 1; r < 32; r++) begin
            if_b.DBG_ADDR_i = 5'(r);
            #0.1;
            chk($sformatf("rst_dbg_x%0d", r), if_b.DBG_DATA_o, 32'd0);
        end
        // Release with the write still presented; first edge afterwards takes it.
        @(negedge clk);
        drive(1'b1, 5'd9, 32'h55, 5'd9, 5'd0, 5'd9);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_cnt", if_b.WR_CNT_o, 32'd1);
        chk("post_rst_dbg9", if_b.DBG_DATA_o, 32'h55);

        // Counter wrap from a forced all-ones value.
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd4);
        force dut_b.r_wr_cnt = 32'hFFFFFFFF;
        #1;
        release dut_b.r_wr_cnt;
        #1;
        chk("wrap_preload", if_b.WR_CNT_o, 32'hFFFFFFFF);
        drive(1'b1, 5'd4, 32'hCAFE0004, 5'd4, 5'd0, 5'd4);
        @(posedge clk);
        #1;
        chk("wrap_cnt", if_b.WR_CNT_o, 32'h0);
        chk("wrap_dbg4", if_b.DBG_DATA_o, 32'hCAFE0004);

        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
